// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch (read-only) and load/store.
// Load/store has priority; a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Handshake: a requester holds req/addr (and we/wdata) stable until it
    // sees gnt high in the same cycle; it may present a new request the next
    // cycle, so one access issues per cycle and reads can run back-to-back.

    typedef enum logic {
        LS_PRI = 1'b0,
        IF_PRI = 1'b1
    } pri_t;

    localparam logic [4:0] MAX_WAIT_C = 5'(MAX_WAIT);

    pri_t        pri_q, pri_d;
    logic [3:0]  wait_q, wait_d;
    logic        if_win, ls_win, rd_issue, if_denied;

    logic [READ_LAT-1:0] pv_q;
    logic [READ_LAT-1:0] pt_q;
    logic                rsp_valid, rsp_tag;

    always_comb begin
        if_win    = rst_n && if_req && (!ls_req || pri_q == IF_PRI);
        ls_win    = rst_n && ls_req && !if_win;
        if_denied = if_req && !if_win;
        rd_issue  = if_win || (ls_win && !ls_we);
    end

    assign if_gnt = if_win;
    assign ls_gnt = ls_win;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_w_en  = 1'b0;
        if (if_win) begin
            ram_addr = if_addr;
        end else if (ls_win) begin
            ram_addr = ls_addr;
            if (ls_we) begin
                ram_wdata = ls_wdata;
                ram_w_en  = 1'b1;
            end
        end
    end

    // Priority FSM: fetch takes priority after MAX_WAIT consecutive denials,
    // and gives it back as soon as it is served or stops asking.
    always_comb begin
        pri_d  = pri_q;
        wait_d = 4'd0;
        if (if_denied) begin
            wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
        end
        case (pri_q)
            LS_PRI: begin
                if (if_denied && ({1'b0, wait_q} + 5'd1 == MAX_WAIT_C)) begin
                    pri_d = IF_PRI;
                end
            end
            IF_PRI: begin
                if (if_win || !if_req) begin
                    pri_d = LS_PRI;
                end
            end
            default: pri_d = LS_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q  <= LS_PRI;
            wait_q <= 4'd0;
        end else begin
            pri_q  <= pri_d;
            wait_q <= wait_d;
        end
    end

    // Read tag pipeline: tag 0 = fetch, 1 = load; advances every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pt_q <= '0;
        end else begin
            pv_q[0] <= rd_issue;
            pt_q[0] <= ls_win;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
        end
    end

    assign rsp_valid = pv_q[READ_LAT-1];
    assign rsp_tag   = pt_q[READ_LAT-1];

    always_comb begin
        if_rvalid = rsp_valid && !rsp_tag;
        ls_rvalid = rsp_valid && rsp_tag;
        if_rdata  = if_rvalid ? ram_rdata : '0;
        ls_rdata  = ls_rvalid ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (READ_LAT 1 and 3) share stimulus,
// each with its own RAM model, checked against a request-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MAX_WAIT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic ram_clr;
    logic if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr;
    logic [DW-1:0] ls_wdata;

    logic [1:0]         if_gnt_v, ls_gnt_v, if_rvalid_v, ls_rvalid_v, ram_w_en_v;
    logic [1:0][DW-1:0] if_rdata_v, ls_rdata_v, ram_wdata_v, ram_rdata_v;
    logic [1:0][AW-1:0] ram_addr_v;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .MAX_WAIT(MAX_WAIT)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_v[0]),
        .if_rvalid(if_rvalid_v[0]), .if_rdata(if_rdata_v[0]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt_v[0]), .ls_rvalid(ls_rvalid_v[0]), .ls_rdata(ls_rdata_v[0]),
        .ram_addr(ram_addr_v[0]), .ram_wdata(ram_wdata_v[0]), .ram_w_en(ram_w_en_v[0]),
        .ram_rdata(ram_rdata_v[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .MAX_WAIT(MAX_WAIT)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_v[1]),
        .if_rvalid(if_rvalid_v[1]), .if_rdata(if_rdata_v[1]),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt_v[1]), .ls_rvalid(ls_rvalid_v[1]), .ls_rdata(ls_rdata_v[1]),
        .ram_addr(ram_addr_v[1]), .ram_wdata(ram_wdata_v[1]), .ram_w_en(ram_w_en_v[1]),
        .ram_rdata(ram_rdata_v[1])
    );

    // Power-up RAM content; word 0x010 holds a known instruction.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 11'h010) return 32'hE3A01005;
        return {5'h15, a, 5'h0A, ~a};
    endfunction

    // RAM models: one word per cycle, data READ_LAT cycles after the address.
    logic [DW-1:0] wmem0 [2048];
    logic [DW-1:0] wmem1 [2048];
    logic [2047:0] wr0, wr1;
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1 [3];

    always @(posedge clk) begin
        if (ram_clr) wr0 <= '0;
        else if (ram_w_en_v[0]) begin
            wr0[ram_addr_v[0]]   <= 1'b1;
            wmem0[ram_addr_v[0]] <= ram_wdata_v[0];
        end
        pipe0 <= wr0[ram_addr_v[0]] ? wmem0[ram_addr_v[0]] : init_word(ram_addr_v[0]);
    end
    assign ram_rdata_v[0] = pipe0;

    always @(posedge clk) begin
        if (ram_clr) wr1 <= '0;
        else if (ram_w_en_v[1]) begin
            wr1[ram_addr_v[1]]   <= 1'b1;
            wmem1[ram_addr_v[1]] <= ram_wdata_v[1];
        end
        pipe1[0] <= wr1[ram_addr_v[1]] ? wmem1[ram_addr_v[1]] : init_word(ram_addr_v[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign ram_rdata_v[1] = pipe1[2];

    // Reference model state: consecutive fetch denials, memory image, and
    // expected responses {due_cycle[15:0], tag, data} per latency.
    int            n_cmp = 0;
    int            n_mis = 0;
    int            cyc = 0;
    int            denied_run = 0;
    logic [DW-1:0] shadow [int];
    logic [48:0]   exp_q0[$];
    logic [48:0]   exp_q1[$];
    logic          m_if_gnt, m_ls_gnt;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
        end
    endtask

    task automatic chk_rsp(input int d, input bit has, input logic [48:0] ent);
        logic tag;
        logic [DW-1:0] data;
        tag  = has ? ent[32] : 1'b0;
        data = ent[31:0];
        chk("if_rvalid", d, if_rvalid_v[d], has && !tag);
        chk("ls_rvalid", d, ls_rvalid_v[d], has && tag);
        chk("if_rdata", d, if_rdata_v[d], (has && !tag) ? data : '0);
        chk("ls_rdata", d, ls_rdata_v[d], (has && tag) ? data : '0);
    endtask

    // One clock: compare at the falling edge, then advance the model.
    task automatic step(input bit row_chk, input logic r_if, input logic r_ls);
        logic e_if, e_ls, e_wen, has;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [48:0] ent;
        @(negedge clk);
        e_if = 1'b0; e_ls = 1'b0; e_wen = 1'b0; e_addr = '0; e_wd = '0;
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            denied_run = 0;
        end else begin
            e_if   = if_req && (!ls_req || denied_run >= MAX_WAIT);
            e_ls   = ls_req && !e_if;
            e_addr = e_if ? if_addr : (e_ls ? ls_addr : '0);
            e_wen  = e_ls && ls_we;
            e_wd   = e_wen ? ls_wdata : '0;
        end
        m_if_gnt = e_if;
        m_ls_gnt = e_ls;
        for (int d = 0; d < 2; d++) begin
            chk("if_gnt", d, if_gnt_v[d], e_if);
            chk("ls_gnt", d, ls_gnt_v[d], e_ls);
            chk("ram_addr", d, ram_addr_v[d], e_addr);
            chk("ram_wdata", d, ram_wdata_v[d], e_wd);
            chk("ram_w_en", d, ram_w_en_v[d], e_wen);
            if (row_chk) begin
                chk("row_if_gnt", d, if_gnt_v[d], r_if);
                chk("row_ls_gnt", d, ls_gnt_v[d], r_ls);
            end
        end
        has = (exp_q0.size() != 0) && (exp_q0[0][48:33] == 16'(cyc));
        ent = has ? exp_q0.pop_front() : '0;
        chk_rsp(0, has, ent);
        has = (exp_q1.size() != 0) && (exp_q1[0][48:33] == 16'(cyc));
        ent = has ? exp_q1.pop_front() : '0;
        chk_rsp(1, has, ent);
        if (rst_n) begin
            if (if_req && !e_if) denied_run = (denied_run < 15) ? denied_run + 1 : 15;
            else denied_run = 0;
            if (e_wen) shadow[int'(ls_addr)] = ls_wdata;
            if (e_if) begin
                exp_q0.push_back({16'(cyc + 1), 1'b0, mem_val(if_addr)});
                exp_q1.push_back({16'(cyc + 3), 1'b0, mem_val(if_addr)});
            end
            if (e_ls && !ls_we) begin
                exp_q0.push_back({16'(cyc + 1), 1'b1, mem_val(ls_addr)});
                exp_q1.push_back({16'(cyc + 3), 1'b1, mem_val(ls_addr)});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic i_req, input logic [AW-1:0] i_addr,
                         input logic l_req, input logic l_we,
                         input logic [AW-1:0] l_addr, input logic [DW-1:0] l_wd);
        if_req = i_req; if_addr = i_addr;
        ls_req = l_req; ls_we = l_we; ls_addr = l_addr; ls_wdata = l_wd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          ls_req;
        logic          ls_we;
        logic [AW-1:0] ls_addr;
        logic [DW-1:0] ls_wdata;
        logic          exp_if_gnt;
        logic          exp_ls_gnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia, input logic lr,
                                input logic lw, input logic [AW-1:0] la,
                                input logic [DW-1:0] ld, input logic eg_if, input logic eg_ls);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
        v.ls_addr = la; v.ls_wdata = ld; v.exp_if_gnt = eg_if; v.exp_ls_gnt = eg_ls;
        return v;
    endfunction

    initial begin
        logic if_pend, ls_pend;
        // Fetch hit, store, load-after-store, starvation run, back-to-back mix.
        vecs.push_back(mk(1, 11'h010, 0, 0, 11'h000, 32'h0, 1, 0));
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h100, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 11'h000, 1, 0, 11'h100, 32'h0, 0, 1));
        vecs.push_back(mk(0, 11'h000, 0, 0, 11'h000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 11'h020, 1, 0, 11'h300, 32'h0, 0, 1));
        vecs.push_back(mk(1, 11'h020, 1, 0, 11'h301, 32'h0, 0, 1));
        vecs.push_back(mk(1, 11'h020, 1, 0, 11'h302, 32'h0, 0, 1));
        vecs.push_back(mk(1, 11'h020, 1, 0, 11'h303, 32'h0, 1, 0));
        vecs.push_back(mk(1, 11'h021, 1, 0, 11'h304, 32'h0, 0, 1));
        vecs.push_back(mk(1, 11'h021, 0, 0, 11'h000, 32'h0, 1, 0));
        vecs.push_back(mk(0, 11'h000, 0, 0, 11'h000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 11'h001, 0, 0, 11'h000, 32'h0, 1, 0));
        vecs.push_back(mk(0, 11'h000, 1, 0, 11'h200, 32'h0, 0, 1));
        vecs.push_back(mk(1, 11'h002, 0, 0, 11'h000, 32'h0, 1, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 11'h000, 0, 0, 11'h000, 32'h0, 0, 0));

        // Reset, then idle.
        rst_n = 1'b0;
        ram_clr = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0);
        ram_clr = 1'b0;
        drive(1'b1, 11'h005, 1'b1, 1'b1, 11'h006, 32'h1234_5678);
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(10);

        foreach (vecs[i]) begin
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_we,
                  vecs[i].ls_addr, vecs[i].ls_wdata);
            step(1'b1, vecs[i].exp_if_gnt, vecs[i].exp_ls_gnt);
        end

        // Reset with reads in flight: nothing may come back afterwards.
        drive(1'b1, 11'h030, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 11'h031, '0);
        step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 11'h033, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(4);
        drive(1'b1, 11'h032, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0);
        idle(4);

        // Random traffic obeying the hold-until-grant rule.
        if_pend = 1'b0;
        ls_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!if_pend) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = 11'($urandom_range(0, 63));
            end
            if (!ls_pend) begin
                ls_req   = ($urandom_range(0, 3) != 0);
                ls_we    = 1'($urandom_range(0, 1));
                ls_addr  = 11'($urandom_range(0, 63));
                ls_wdata = $urandom;
            end
            step(1'b0, 1'b0, 1'b0);
            if_pend = if_req && !m_if_gnt;
            ls_pend = ls_req && !m_ls_gnt;
        end
        idle(6);
        chk("drain_q_l1", 0, 64'(exp_q0.size()), 64'd0);
        chk("drain_q_l3", 1, 64'(exp_q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
